// File: rtl/apb_regfile_ws.sv
// APB4 completer register file: fixed wait-state insertion, byte strobes,
// read-only status slots sourced from hw_status, and access-phase protocol checks.
module apb_regfile_ws #(
   parameter int                  DATA_WIDTH  = 32,
   parameter int                  ADDR_WIDTH  = 8,
   parameter int                  NUM_REGS    = 16,
   parameter int                  WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
   input  logic                           pclk,
   input  logic                           presetn,
   input  logic                           psel,
   input  logic                           penable,
   input  logic                           pwrite,
   input  logic [ADDR_WIDTH-1:0]          paddr,
   input  logic [DATA_WIDTH-1:0]          pwdata,
   input  logic [DATA_WIDTH/8-1:0]        pstrb,
   output logic [DATA_WIDTH-1:0]          prdata,
   output logic                           pready,
   output logic                           pslverr,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

   localparam int                    ALIGN     = $clog2(DATA_WIDTH/8);
   localparam int                    STRB_W    = DATA_WIDTH/8;
   localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'((1 << ALIGN) - 1);
   localparam logic [ADDR_WIDTH:0]   NREG_L    = (ADDR_WIDTH+1)'(NUM_REGS);
   localparam logic [3:0]            WS_L      = 4'(WAIT_STATES);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [3:0]              wcnt_r;
   logic [3:0]              wcnt_nxt_s;
   logic                    err_r;
   logic                    err_nxt_s;
   logic                    mism_r;
   logic                    mism_nxt_s;
   logic                    mism_now_s;
   logic                    capture_s;
   logic                    complete_s;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic                    write_r;
   logic [DATA_WIDTH-1:0]   wdata_r;
   logic [STRB_W-1:0]       strb_r;
   logic [ADDR_WIDTH-1:0]   acc_idx_s;
   logic                    pready_s;
   logic                    ok_s;
   logic                    wr_en_s;
   logic [DATA_WIDTH-1:0]   rd_mux_s;
   logic [DATA_WIDTH-1:0]   regs_r [NUM_REGS];

   function automatic logic [ADDR_WIDTH-1:0] reg_index(input logic [ADDR_WIDTH-1:0] a);
      return a >> ALIGN;
   endfunction

   // Misaligned, out-of-range, or write to a read-only slot.
   function automatic logic setup_err(input logic [ADDR_WIDTH-1:0] a, input logic wr);
      logic [ADDR_WIDTH-1:0] idx;
      logic                  e;
      idx = reg_index(a);
      e   = |(a & OFFS_MASK);
      if ({1'b0, idx} >= NREG_L) begin
         e = 1'b1;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
         if (wr && RO_MASK[i] && (idx == ADDR_WIDTH'(i))) begin
            e = 1'b1;
         end
      end
      return e;
   endfunction

   assign acc_idx_s  = reg_index(addr_r);
   assign mism_now_s = mism_r | (paddr != addr_r) | (pwrite != write_r);
   assign pready_s   = (state_r == ST_ACCESS) && (wcnt_r == 4'd0);
   assign ok_s       = !err_r && !mism_now_s;
   assign wr_en_s    = complete_s && write_r && ok_s;

   // Next-state, wait counter and error bookkeeping for the transfer FSM
   always_comb begin
      state_nxt_s = state_r;
      wcnt_nxt_s  = wcnt_r;
      err_nxt_s   = err_r;
      mism_nxt_s  = mism_r;
      capture_s   = 1'b0;
      complete_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (psel) begin
               state_nxt_s = ST_ACCESS;
               capture_s   = 1'b1;
               mism_nxt_s  = 1'b0;
               if (penable) begin
                  // access phase with no preceding setup cycle
                  wcnt_nxt_s = 4'd0;
                  err_nxt_s  = 1'b1;
               end else begin
                  wcnt_nxt_s = WS_L;
                  err_nxt_s  = setup_err(paddr, pwrite);
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (psel && penable) begin
               mism_nxt_s = mism_now_s;
               if (wcnt_r == 4'd0) begin
                  state_nxt_s = ST_IDLE;
                  complete_s  = 1'b1;
               end else begin
                  wcnt_nxt_s = wcnt_r - 4'd1;
               end
            end else begin
               state_nxt_s = ST_IDLE;
               wcnt_nxt_s  = 4'd0;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            wcnt_nxt_s  = 4'd0;
         end
      endcase
   end

   // FSM state, counter and latched transfer fields
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_r <= ST_IDLE;
         wcnt_r  <= 4'd0;
         err_r   <= 1'b0;
         mism_r  <= 1'b0;
         addr_r  <= '0;
         write_r <= 1'b0;
         wdata_r <= '0;
         strb_r  <= '0;
      end else begin
         state_r <= state_nxt_s;
         wcnt_r  <= wcnt_nxt_s;
         err_r   <= err_nxt_s;
         mism_r  <= mism_nxt_s;
         if (capture_s) begin
            addr_r  <= paddr;
            write_r <= pwrite;
            wdata_r <= pwdata;
            strb_r  <= pstrb;
         end
      end
   end

   // Register file: lane-wise update on an error-free write completion
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= '0;
         end
      end else if (wr_en_s) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            for (int b = 0; b < STRB_W; b++) begin
               if (!RO_MASK[i] && (acc_idx_s == ADDR_WIDTH'(i)) && strb_r[b]) begin
                  regs_r[i][b*8 +: 8] <= wdata_r[b*8 +: 8];
               end
            end
         end
      end
   end

   // Read mux over the latched index; RO slots return the live status input
   always_comb begin
      rd_mux_s = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         rd_mux_s = rd_mux_s |
                    ({DATA_WIDTH{acc_idx_s == ADDR_WIDTH'(i)}} &
                     (RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH] : regs_r[i]));
      end
   end

   assign pready  = pready_s;
   assign pslverr = pready_s && !ok_s;
   assign prdata  = (pready_s && !write_r && ok_s) ? rd_mux_s : '0;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
      assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : regs_r[g];
   end

endmodule
